multiport_regfile: RTL



---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_read_port.sv | 40 ++++
 rtl/multiport_regfile.sv | 106 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file: the clear/run state
// encoding, default geometry, and the packed-port slice offset used by every file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Low bit of port 'port' inside a bus that packs ports of 'width' bits each.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array select, same-cycle write bypass (only when
// REGFILE_BYPASS_EN is defined), and zero masking for r0 and for the clear phase.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                run,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   regs [2**ADDR_W],
  input  logic [1:0]          wr_en,
  input  logic [2*ADDR_W-1:0] wr_addr,
  input  logic [2*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]   data
);

`ifndef REGFILE_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first; a path
    // that leaves it unassigned would infer a latch.
    data = regs[addr];
`ifdef REGFILE_BYPASS_EN
    // Port 1 is tested last so it overrides port 0 when both match.
    if (wr_en[0] && wr_addr[slice_lo(0, ADDR_W) +: ADDR_W] == addr)
      data = wr_data[slice_lo(0, DATA_W) +: DATA_W];
    if (wr_en[1] && wr_addr[slice_lo(1, ADDR_W) +: ADDR_W] == addr)
      data = wr_data[slice_lo(1, DATA_W) +: DATA_W];
`endif
    // The mask comes last so it also suppresses any bypass onto r0 or during clear.
    if (!run || (ZERO_REG != 0 && addr == '0))
      data = '0;
  end

endmodule

// File: rtl/multiport_regfile.sv
// NUM_RD-read / 2-write register file with optional hardwired r0 and a clear
// sequencer that zeroes the array after reset or on clear_req.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [1:0]               wr_en,
  input  logic [2*ADDR_W-1:0]      wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic                     clear_req,
  output logic                     ready
);

  localparam int                NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  rf_state_e         state, state_next;
  logic [ADDR_W-1:0] clr_idx;
  logic              run;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [ADDR_W-1:0] wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              we0, we1;

  assign run = (state == RUN);

  // State register and clear counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR)
        clr_idx <= clr_idx + 1'b1;
      else if (clear_req)
        clr_idx <= '0;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      CLEAR:   if (clr_idx == LAST_IDX) state_next = RUN;
      RUN:     if (clear_req)           state_next = CLEAR;
      default:                          state_next = CLEAR;
    endcase
  end

  always_comb begin
    ready = (state == RUN);
  end

  assign wa0 = wr_addr[slice_lo(0, ADDR_W) +: ADDR_W];
  assign wa1 = wr_addr[slice_lo(1, ADDR_W) +: ADDR_W];
  assign wd0 = wr_data[slice_lo(0, DATA_W) +: DATA_W];
  assign wd1 = wr_data[slice_lo(1, DATA_W) +: DATA_W];

  // Port 0 is dropped on an address collision so port 1 wins unambiguously.
  assign we0 = run && !rst && wr_en[0]
               && !(ZERO_REG != 0 && wa0 == '0)
               && !(wr_en[1] && wa1 == wa0);
  assign we1 = run && !rst && wr_en[1]
               && !(ZERO_REG != 0 && wa1 == '0);

  // NOTE: the array is deliberately left out of reset; the clear sequencer
  // zeroes it one entry per cycle so it maps onto plain RAM/flop arrays.
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR)
      regs[clr_idx] <= '0;
    if (we0)
      regs[wa0] <= wd0;
    if (we1)
      regs[wa1] <= wd1;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .run     (run),
      .addr    (rd_addr[slice_lo(k, ADDR_W) +: ADDR_W]),
      .regs    (regs),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data[slice_lo(k, DATA_W) +: DATA_W])
    );
  end

endmodule
